// File: rtl/ucode_mul_sequencer_if.sv
// Fetch-side handshake for the multiply micro-sequencer: entry context in,
// ghost_PC in, micro-instruction and status out.
interface ucode_mul_sequencer_if;
  logic        ucode_start;
  logic [6:0]  mul_opcode;
  logic [3:0]  mul_rd;
  logic [3:0]  mul_rs;
  logic [15:0] mul_imm;
  logic [3:0]  ghost_PC;
  logic [31:0] ghost_instruction;
  logic        ucode_done;
  logic        busy;

  modport master (
    output ucode_start, mul_opcode, mul_rd, mul_rs, mul_imm, ghost_PC,
    input  ghost_instruction, ucode_done, busy
  );

  modport slave (
    input  ucode_start, mul_opcode, mul_rd, mul_rs, mul_imm, ghost_PC,
    output ghost_instruction, ucode_done, busy
  );
endinterface

// File: rtl/ucode_mul_sequencer.sv
// Shift-add multiply micro-program generator: latches the multiply context at
// entry and decodes ghost_PC into micro-instructions with per-iteration substitution.
module ucode_mul_sequencer (
  input  logic                         clk,
  input  logic                         rst,
  ucode_mul_sequencer_if.slave         bus
);
  localparam logic [3:0] REG_T0 = 4'd13;
  localparam logic [3:0] REG_T1 = 4'd14;
  localparam logic [3:0] REG_T2 = 4'd15;

  localparam logic [6:0] OP_MOVI = 7'b0001001;
  localparam logic [6:0] OP_MOV  = 7'b0001000;
  localparam logic [6:0] OP_ADD  = 7'b0000000;
  localparam logic [6:0] OP_ADDP = 7'b0000100;
  localparam logic [6:0] OP_SUB  = 7'b0000001;
  localparam logic [6:0] OP_SUBP = 7'b0000101;
  localparam logic [6:0] OP_SHLI = 7'b0001100;
  localparam logic [6:0] OP_SHRI = 7'b0001101;

  localparam logic [31:0] INSTR_NOP  = {7'b1100100, 25'b0};
  localparam logic [31:0] INSTR_LOOP = {11'b11000010000, 21'b0};
  localparam logic [31:0] INSTR_EXIT = {4'b1101, 28'b0};

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t      state;
  logic [3:0]  iter;
  logic        ctx_is_imm;
  logic        ctx_is_signed;
  logic [3:0]  ctx_rd;
  logic [3:0]  ctx_rs;
  logic [15:0] ctx_imm;
  logic        start_valid;
  logic        active;
  logic        last_iter;

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs, input logic [15:0] imm);
    return {op, rd, rs, 1'b0, imm};
  endfunction

  always_comb begin
    start_valid = (bus.mul_opcode == 7'b0010000) || (bus.mul_opcode == 7'b0110000) ||
                  (bus.mul_opcode == 7'b0011000) || (bus.mul_opcode == 7'b0111000);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      iter          <= 4'd0;
      ctx_is_imm    <= 1'b0;
      ctx_is_signed <= 1'b0;
      ctx_rd        <= 4'd0;
      ctx_rs        <= 4'd0;
      ctx_imm       <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.ucode_start && start_valid) begin
            ctx_is_imm    <= bus.mul_opcode[3];
            ctx_is_signed <= bus.mul_opcode[5];
            ctx_rd        <= bus.mul_rd;
            ctx_rs        <= bus.mul_rs;
            ctx_imm       <= bus.mul_imm;
            iter          <= 4'd0;
            state         <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          // The loop-back line is the iteration boundary; the count saturates at 15.
          if (bus.ghost_PC == 4'd6 && iter != 4'd15) begin
            iter <= iter + 4'd1;
          end
          if (bus.ghost_PC == 4'd9) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign active    = (state == S_ACTIVE);
  assign last_iter = (iter == 4'd15);

  assign bus.busy       = active;
  assign bus.ucode_done = active && (bus.ghost_PC == 4'd9);

  always_comb begin
    bus.ghost_instruction = INSTR_NOP;
    if (active) begin
      case (bus.ghost_PC)
        4'd0: bus.ghost_instruction = mk(OP_MOVI, REG_T0, 4'd0, 16'd0);
        4'd1: bus.ghost_instruction = mk(OP_MOV, REG_T1, ctx_rs, 16'd0);
        4'd2: if (!ctx_is_imm) bus.ghost_instruction = mk(OP_MOV, REG_T2, ctx_rd, 16'd0);
        4'd3: begin
          if (!ctx_is_imm)
            bus.ghost_instruction = mk(OP_ADDP, REG_T0, REG_T1, 16'd0);
          else if (ctx_imm[iter])
            bus.ghost_instruction = mk(OP_ADD, REG_T0, REG_T1, 16'd0);
        end
        4'd4: bus.ghost_instruction = mk(OP_SHLI, REG_T1, 4'd0, 16'd1);
        // Last shift skipped so T2[0] still holds the multiplier sign for line 7.
        4'd5: if (!ctx_is_imm && !last_iter)
                bus.ghost_instruction = mk(OP_SHRI, REG_T2, 4'd0, 16'd1);
        4'd6: if (!last_iter) bus.ghost_instruction = INSTR_LOOP;
        4'd7: begin
          if (ctx_is_signed && !ctx_is_imm)
            bus.ghost_instruction = mk(OP_SUBP, REG_T0, REG_T1, 16'd0);
          else if (ctx_is_signed && ctx_imm[15])
            bus.ghost_instruction = mk(OP_SUB, REG_T0, REG_T1, 16'd0);
        end
        4'd8: bus.ghost_instruction = mk(OP_MOV, ctx_rd, REG_T0, 16'd0);
        4'd9: bus.ghost_instruction = INSTR_EXIT;
        default: bus.ghost_instruction = INSTR_NOP;
      endcase
    end
  end
endmodule
